// File: rtl/mem_port_arbiter_if.sv
// Request/grant and memory-side bundle for mem_port_arbiter.
// The arbiter uses the slave modport; requesters and the memory use the master modport.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_lock;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data/stack memory between the CPU sequencer and the debug port,
// with a CPU lock for atomic stack sequences and a starvation guard for debug.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_OWN = 2'd1,
        DBG_OWN = 2'd2
    } state_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t            state;
    logic [7:0]        starve_cnt;
    logic              lock_hold;
    logic              cpu_gnt_c;
    logic              dbg_gnt_c;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              tag_cpu;
    logic              tag_dbg;
    logic              cpu_rvalid_q;
    logic              dbg_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    // An active lock blocks debug even on cycles where the CPU is not requesting.
    always_comb begin
        lock_hold = (state == CPU_OWN) && bus.cpu_lock;
        cpu_gnt_c = 1'b0;
        dbg_gnt_c = 1'b0;
        if (lock_hold) begin
            cpu_gnt_c = bus.cpu_req;
        end else if (bus.dbg_req && (starve_cnt == STARVE_MAX)) begin
            dbg_gnt_c = 1'b1;
        end else if (bus.cpu_req) begin
            cpu_gnt_c = 1'b1;
        end else if (bus.dbg_req) begin
            dbg_gnt_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tag_cpu      <= 1'b0;
            tag_dbg      <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            if (cpu_gnt_c) begin
                mem_en_q    <= 1'b1;
                mem_we_q    <= bus.cpu_we;
                mem_addr_q  <= bus.cpu_addr;
                mem_wdata_q <= bus.cpu_wdata;
            end else if (dbg_gnt_c) begin
                mem_en_q    <= 1'b1;
                mem_we_q    <= bus.dbg_we;
                mem_addr_q  <= bus.dbg_addr;
                mem_wdata_q <= bus.dbg_wdata;
            end else begin
                mem_en_q <= 1'b0;
                mem_we_q <= 1'b0;
            end

            // Read tags ride one stage behind the issue so rvalid lines up with mem_rdata.
            tag_cpu      <= cpu_gnt_c & ~bus.cpu_we;
            tag_dbg      <= dbg_gnt_c & ~bus.dbg_we;
            cpu_rvalid_q <= tag_cpu;
            dbg_rvalid_q <= tag_dbg;
            if (cpu_rvalid_q) cpu_rdata_q <= bus.mem_rdata;
            if (dbg_rvalid_q) dbg_rdata_q <= bus.mem_rdata;

            if (cpu_gnt_c || lock_hold) state <= CPU_OWN;
            else if (dbg_gnt_c)         state <= DBG_OWN;
            else                        state <= IDLE;

            if (bus.dbg_req && !dbg_gnt_c) begin
                if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 8'd1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    assign bus.cpu_gnt    = cpu_gnt_c;
    assign bus.dbg_gnt    = dbg_gnt_c;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    // The owning port sees memory data directly; the other port keeps its last read.
    assign bus.cpu_rdata  = cpu_rvalid_q ? bus.mem_rdata : cpu_rdata_q;
    assign bus.dbg_rdata  = dbg_rvalid_q ? bus.mem_rdata : dbg_rdata_q;
    assign bus.owner      = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a cycle-level reference model
// built from the arbitration rules, a shadow memory and a queue of outstanding reads.
module tb_mem_port_arbiter;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(
        .ADDR_W(16),
        .DATA_W(16),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Synchronous single-port memory seen by the arbiter.
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    function automatic logic [15:0] init_val(input int a);
        return 16'((a * 40503) ^ 16'hA5C3);
    endfunction

    typedef struct {
        int          port;
        logic [15:0] data;
        int          due;
    } rd_t;

    int            tests_run = 0;
    int            tests_failed = 0;
    int            cyc = 0;
    int            m_state = 0;
    int            m_starve = 0;
    logic          m_en = 1'b0, m_we = 1'b0;
    logic [15:0]   m_addr = '0, m_wdata = '0;
    logic [15:0]   ref_mem [int];
    rd_t           rd_q [$];
    logic [15:0]   c_last, d_last;
    bit            c_has = 0, d_has = 0;
    logic          last_cgnt = 1'b0, last_dgnt = 1'b0;

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(int'(a));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive_cpu(input logic req, input logic we, input logic lock,
                             input logic [15:0] addr, input logic [15:0] wdata);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_lock = lock;
        bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    endtask

    task automatic drive_dbg(input logic req, input logic we,
                             input logic [15:0] addr, input logic [15:0] wdata);
        bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
    endtask

    // One clock cycle: check DUT mid-cycle against the model, then advance the model.
    task automatic tick();
        logic lh, ec, ed, xc, xd, w;
        logic [15:0] a, wd;
        int port;
        @(negedge clk);
        lh = (m_state == 1) && bus.cpu_lock;
        ec = 1'b0;
        ed = 1'b0;
        if (lh)                                    ec = bus.cpu_req;
        else if (bus.dbg_req && m_starve == LIMIT) ed = 1'b1;
        else if (bus.cpu_req)                      ec = 1'b1;
        else if (bus.dbg_req)                      ed = 1'b1;

        xc = (rd_q.size() > 0) && (rd_q[0].due == cyc) && (rd_q[0].port == 0);
        xd = (rd_q.size() > 0) && (rd_q[0].due == cyc) && (rd_q[0].port == 1);

        check("cpu_gnt", 32'(bus.cpu_gnt), 32'(ec));
        check("dbg_gnt", 32'(bus.dbg_gnt), 32'(ed));
        check("gnt_exclusive", 32'(bus.cpu_gnt & bus.dbg_gnt), 32'd0);
        check("owner", 32'(bus.owner), 32'(m_state));
        check("mem_en", 32'(bus.mem_en), 32'(m_en));
        check("mem_we", 32'(bus.mem_we), 32'(m_we));
        check("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        check("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
        check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(xc));
        check("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(xd));
        if (xc) begin c_last = rd_q[0].data; c_has = 1; end
        if (xd) begin d_last = rd_q[0].data; d_has = 1; end
        if (c_has) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(c_last));
        if (d_has) check("dbg_rdata", 32'(bus.dbg_rdata), 32'(d_last));
        if (rd_q.size() > 0 && rd_q[0].due == cyc) void'(rd_q.pop_front());

        last_cgnt = ec;
        last_dgnt = ed;
        if (reset) begin
            m_state = 0; m_starve = 0;
            m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            rd_q.delete();
            c_has = 0; d_has = 0;
        end else begin
            if (ec || ed) begin
                port = ec ? 0 : 1;
                w  = ec ? bus.cpu_we    : bus.dbg_we;
                a  = ec ? bus.cpu_addr  : bus.dbg_addr;
                wd = ec ? bus.cpu_wdata : bus.dbg_wdata;
                m_en = 1; m_we = w; m_addr = a; m_wdata = wd;
                if (w) ref_mem[int'(a)] = wd;
                else   rd_q.push_back('{port: port, data: ref_rd(a), due: cyc + 2});
            end else begin
                m_en = 0; m_we = 0;
            end
            m_state  = (ec || lh) ? 1 : (ed ? 2 : 0);
            m_starve = (bus.dbg_req && !ed) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
        mem[16'h0010]     = 16'hBEEF;
        ref_mem[16'h0010] = 16'hBEEF;
        drive_cpu(0, 0, 0, '0, '0);
        drive_dbg(0, 0, '0, '0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // CPU read of 0x0010 returning 0xBEEF two cycles after grant.
        drive_cpu(1, 0, 0, 16'h0010, '0);
        tick();
        drive_cpu(0, 0, 0, '0, '0);
        repeat (3) tick();

        // Both requesting: CPU wins until debug starves, then debug gets one slot.
        drive_cpu(1, 0, 0, 16'h0020, '0);
        drive_dbg(1, 0, 16'h0030, '0);
        repeat (12) tick();
        drive_cpu(0, 0, 0, '0, '0);
        drive_dbg(0, 0, '0, '0);
        repeat (3) tick();

        // Locked push sequence with a request gap; debug must wait for the release.
        drive_dbg(1, 1, 16'h0040, 16'h5555);
        drive_cpu(1, 1, 1, 16'h00F0, 16'h1111); tick();
        drive_cpu(1, 1, 1, 16'h00EF, 16'h2222); tick();
        drive_cpu(0, 0, 1, '0, '0);             tick();
        drive_cpu(1, 1, 1, 16'h00EE, 16'h3333); tick();
        drive_cpu(0, 0, 0, '0, '0);             tick();
        drive_dbg(0, 0, '0, '0);
        repeat (2) tick();

        // Debug write then CPU read of the same address on the next cycle.
        drive_dbg(1, 1, 16'h0100, 16'h1234); tick();
        drive_dbg(0, 0, '0, '0);
        drive_cpu(1, 0, 0, 16'h0100, '0);    tick();
        drive_cpu(0, 0, 0, '0, '0);
        repeat (3) tick();

        // Reset in the cycle after a CPU read grant drops the read.
        drive_cpu(1, 0, 0, 16'h0010, '0); tick();
        drive_cpu(0, 0, 0, '0, '0);
        reset = 1'b1;                     tick();
        reset = 1'b0;
        repeat (3) tick();

        // Alternating CPU and debug reads.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin drive_cpu(1, 0, 0, 16'h0001, '0); drive_dbg(0, 0, '0, '0); end
            else            begin drive_cpu(0, 0, 0, '0, '0); drive_dbg(1, 0, 16'h0002, '0); end
            tick();
        end
        drive_cpu(0, 0, 0, '0, '0);
        drive_dbg(0, 0, '0, '0);
        repeat (3) tick();

        // Random traffic; a pending request is held until it is granted.
        for (int i = 0; i < 400; i++) begin
            if (!(bus.cpu_req && !last_cgnt))
                drive_cpu(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) == 0), 16'($urandom_range(0, 15)), 16'($urandom));
            if (!(bus.dbg_req && !last_dgnt))
                drive_dbg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          16'($urandom_range(0, 15)), 16'($urandom));
            reset = ($urandom_range(0, 79) == 0);
            tick();
        end
        reset = 1'b0;
        drive_cpu(0, 0, 0, '0, '0);
        drive_dbg(0, 0, '0, '0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port synchronous data/stack memory between two requesters: the CPU control sequencer (fetch, load, push/pop, call/ret) and a debug/loader port.
- Issues one memory access per cycle and routes read data back to the requester that issued it.
- A CPU lock keeps multi-cycle stack sequences (push, pop, call, ret) atomic.
- A starvation counter guarantees forward progress for the debug port.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- STARVE_LIMIT, 8, number of consecutive denied debug-request cycles after which debug wins over CPU (range 1..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held with addr/we/wdata until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_lock  in  1  CPU holds ownership across consecutive accesses.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  request accepted this cycle (combinational).
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug port; same semantics as the CPU equivalents.
- dbg_gnt, dbg_rvalid  out  1  debug grant / read valid.
- dbg_rdata  out  DATA_W  debug read data.
- mem_en  out  1  memory access strobe (registered).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we=0.
- owner  out  2  current ownership state: 0 = IDLE, 1 = CPU_OWN, 2 = DBG_OWN.

Behaviour:
- Reset (synchronous): state IDLE, starve_cnt 0, all mem_* 0, both rvalid 0, pending-read tags cleared. A read in flight at reset is dropped: no rvalid afterward.
- Grant decision is combinational in cycle k, evaluated in priority order:
  1. state == CPU_OWN and cpu_lock: CPU only. cpu_gnt = cpu_req; dbg_gnt = 0, even if cpu_req is low.
  2. dbg_req and starve_cnt == STARVE_LIMIT: dbg_gnt = 1.
  3. cpu_req: cpu_gnt = 1.
  4. dbg_req: dbg_gnt = 1.
  5. Otherwise no grant.
- cpu_gnt and dbg_gnt are never high together.
- Next state:
  - CPU_OWN if cpu_gnt, or if rule 1 applied.
  - DBG_OWN if dbg_gnt.
  - Else IDLE.
- Lock:
  - cpu_lock sampled with cpu_gnt enters the lock.
  - Lock persists while cpu_lock = 1.
  - cpu_lock = 0 in CPU_OWN releases it the same cycle, and arbitration proceeds normally.
  - cpu_lock ignored outside CPU_OWN when cpu_req = 0.
- Issue timing: at the edge ending cycle k, the winner's addr/we/wdata load into mem_* and mem_en = 1 for cycle k+1. With no grant, mem_en = 0 and mem_we = 0.
- Requesters may change or drop req at the edge after seeing gnt.
- Reads:
  - Tag captured with issue.
  - In cycle k+2, the owning port's rvalid = 1 and its rdata = mem_rdata.
  - The non-owning rvalid = 0; its rdata holds its last value.
  - Latency gnt→rvalid = 2 cycles; back-to-back reads give one rvalid per cycle.
- Writes: no rvalid; write completes in cycle k+1.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle dbg_req = 1 and dbg_gnt = 0.
  - Clears when dbg_gnt = 1 or dbg_req = 0.
  - The lock overrides starvation, and starve_cnt keeps saturating while locked.
- Simultaneous requests with no lock and no starvation: CPU wins.
- Read then write to the same address on consecutive cycles: memory order preserved; the read returns the old data.

Test Plan:
- CPU read, addr 0x0010, mem holds 0xBEEF -> cpu_gnt in cycle 0; mem_en=1, mem_addr=0x0010 in cycle 1; cpu_rvalid=1, cpu_rdata=0xBEEF in cycle 2; dbg_rvalid stays 0.
- Both requesting continuously, STARVE_LIMIT=8, no lock -> CPU granted cycles 0-7; dbg_gnt in cycle 8; starve_cnt back to 0; CPU granted cycle 9.
- CPU push sequence: cpu_lock=1 for 4 cycles with a 1-cycle cpu_req gap, dbg_req high throughout -> dbg_gnt=0 during the whole lock, including the gap; dbg granted the first cycle cpu_lock=0.
- Debug writes 0x1234 to 0x0100, then CPU reads 0x0100 the next cycle -> mem_we=1 then 0; cpu_rdata=0x1234.
- Reset asserted in the cycle after a CPU read grant -> no cpu_rvalid; owner=0 and all mem_* = 0 the cycle after reset.
- Alternating CPU reads 0x0001 and debug reads 0x0002 -> each rvalid pulses only on the owning port, in the correct order, with the correct data.
